// File: rtl/turn_scheduler.sv
// Battle turn sequencer: orders the two attacks by speed, drives the damage
// calculator select, drains defender HP one point per step and waits for ENTER.
module turn_scheduler #(
    parameter int          CALC_LAT    = 2,
    parameter int          STEP_CYCLES = 16,
    parameter logic [7:0]  ENTER_KEY   = 8'h28
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_turn,
    input  logic [7:0] player_speed,
    input  logic [7:0] enemy_speed,
    input  logic [7:0] player_hp,
    input  logic [7:0] enemy_hp,
    input  logic [7:0] damage,
    input  logic [7:0] keycode,
    output logic       is_player,
    output logic       hp_we,
    output logic       hp_sel,
    output logic [7:0] hp_wdata,
    output logic       busy,
    output logic       turn_done,
    output logic       faint_player,
    output logic       faint_enemy
);

    typedef enum logic [2:0] {IDLE, ORDER, CALC, DRAIN, ACK, DONE} state_t;

    localparam int CW = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1;
    localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] CALC_LAST = CW'(CALC_LAT - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

    state_t          state, state_d;
    logic            first_is_player, first_is_player_d;
    logic            move_num, move_num_d;
    logic [7:0]      target, target_d;
    logic [SW-1:0]   step_cnt, step_cnt_d;
    logic [CW-1:0]   calc_cnt, calc_cnt_d;
    logic            key_prev, key_prev_d;
    logic            faint_player_d, faint_enemy_d;

    logic            attacker_is_player;
    logic [7:0]      attacker_hp;
    logic [7:0]      defender_hp;
    logic            key_now;
    logic            key_edge;

    assign attacker_is_player = first_is_player ^ move_num;
    assign attacker_hp        = attacker_is_player ? player_hp : enemy_hp;
    assign defender_hp        = attacker_is_player ? enemy_hp : player_hp;
    assign key_now            = (keycode == ENTER_KEY);
    assign key_edge           = key_now & ~key_prev;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            first_is_player <= 1'b0;
            move_num        <= 1'b0;
            target          <= 8'd0;
            step_cnt        <= '0;
            calc_cnt        <= '0;
            key_prev        <= 1'b0;
            faint_player    <= 1'b0;
            faint_enemy     <= 1'b0;
        end else begin
            state           <= state_d;
            first_is_player <= first_is_player_d;
            move_num        <= move_num_d;
            target          <= target_d;
            step_cnt        <= step_cnt_d;
            calc_cnt        <= calc_cnt_d;
            key_prev        <= key_prev_d;
            faint_player    <= faint_player_d;
            faint_enemy     <= faint_enemy_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d           = state;
        first_is_player_d = first_is_player;
        move_num_d        = move_num;
        target_d          = target;
        step_cnt_d        = step_cnt;
        calc_cnt_d        = calc_cnt;
        key_prev_d        = key_now;
        faint_player_d    = faint_player;
        faint_enemy_d     = faint_enemy;

        hp_we     = 1'b0;
        hp_sel    = 1'b0;
        hp_wdata  = 8'd0;
        turn_done = 1'b0;
        busy      = (state != IDLE) && (state != DONE);
        is_player = ((state == CALC) || (state == DRAIN) || (state == ACK)) && attacker_is_player;

        case (state)
            IDLE: begin
                if (start_turn) begin
                    faint_player_d = 1'b0;
                    faint_enemy_d  = 1'b0;
                    state_d        = ORDER;
                end
            end

            ORDER: begin
                first_is_player_d = (player_speed >= enemy_speed);
                move_num_d        = 1'b0;
                calc_cnt_d        = '0;
                state_d           = CALC;
            end

            CALC: begin
                // A fainted attacker forfeits its move without a write or ACK.
                if ((calc_cnt == '0) && (attacker_hp == 8'd0)) begin
                    if (!move_num) begin
                        move_num_d = 1'b1;
                        calc_cnt_d = '0;
                    end else begin
                        state_d = DONE;
                    end
                end else if (calc_cnt == CALC_LAST) begin
                    target_d   = (damage >= defender_hp) ? 8'd0 : (defender_hp - damage);
                    step_cnt_d = '0;
                    state_d    = DRAIN;
                end else begin
                    calc_cnt_d = calc_cnt + 1'b1;
                end
            end

            DRAIN: begin
                if (defender_hp <= target) begin
                    state_d = ACK;
                end else if (step_cnt == STEP_LAST) begin
                    hp_we      = 1'b1;
                    hp_sel     = attacker_is_player;
                    hp_wdata   = defender_hp - 8'd1;
                    step_cnt_d = '0;
                end else begin
                    step_cnt_d = step_cnt + 1'b1;
                end
            end

            ACK: begin
                if (key_edge) begin
                    if (target == 8'd0) begin
                        if (attacker_is_player) faint_enemy_d  = 1'b1;
                        else                    faint_player_d = 1'b1;
                        state_d = DONE;
                    end else if (!move_num) begin
                        move_num_d = 1'b1;
                        calc_cnt_d = '0;
                        state_d    = CALC;
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                turn_done = 1'b1;
                state_d   = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_turn_scheduler.sv
// Scoreboard bench for turn_scheduler: expected HP writes and end-of-turn flags
// are queued by the stimulus and consumed by an independent monitor.
module tb_turn_scheduler;

    localparam int          CALC_LAT    = 2;
    localparam int          STEP_CYCLES = 4;
    localparam logic [7:0]  ENTER       = 8'h28;

    typedef struct packed { logic sel; logic [7:0] wdata; } we_t;
    typedef struct packed { logic fp; logic fe; } done_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_turn = 1'b0;
    logic [7:0] player_speed = 8'd0, enemy_speed = 8'd0;
    logic [7:0] player_hp, enemy_hp;
    logic [7:0] damage;
    logic [7:0] keycode = 8'd0;
    logic       is_player, hp_we, hp_sel, busy, turn_done, faint_player, faint_enemy;
    logic [7:0] hp_wdata;

    logic [7:0] dmg_p = 8'd0, dmg_e = 8'd0;
    logic [7:0] init_php = 8'd0, init_ehp = 8'd0;
    logic       hp_load = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int exp_done_total = 0;
    we_t   exp_we[$];
    done_t exp_done[$];
    int    we_cycles[$];
    logic  prev_we = 1'b0;

    turn_scheduler #(.CALC_LAT(CALC_LAT), .STEP_CYCLES(STEP_CYCLES), .ENTER_KEY(ENTER)) dut (
        .clk(clk), .rst_n(rst_n), .start_turn(start_turn),
        .player_speed(player_speed), .enemy_speed(enemy_speed),
        .player_hp(player_hp), .enemy_hp(enemy_hp), .damage(damage), .keycode(keycode),
        .is_player(is_player), .hp_we(hp_we), .hp_sel(hp_sel), .hp_wdata(hp_wdata),
        .busy(busy), .turn_done(turn_done),
        .faint_player(faint_player), .faint_enemy(faint_enemy)
    );

    always #5 clk = ~clk;

    // Damage calculator and HP register models.
    assign damage = is_player ? dmg_p : dmg_e;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (hp_load) begin
            player_hp <= init_php;
            enemy_hp  <= init_ehp;
        end else if (hp_we) begin
            if (hp_sel) enemy_hp  <= hp_wdata;
            else        player_hp <= hp_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: consumes the scoreboard whenever the DUT presents a write or turn_done.
    always @(negedge clk) begin
        if (rst_n) begin
            if (hp_we) begin
                we_cycles.push_back(cyc);
                check("hp_we back-to-back", {31'd0, prev_we}, 32'd0);
                if (exp_we.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected hp_we: sel=%0d wdata=%0d", hp_sel, hp_wdata);
                end else begin
                    we_t e;
                    e = exp_we.pop_front();
                    check("hp write sel/wdata", {23'd0, hp_sel, hp_wdata}, {23'd0, e.sel, e.wdata});
                end
            end
            if (turn_done) begin
                done_cnt++;
                check("busy low in done", {31'd0, busy}, 32'd0);
                if (exp_done.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected turn_done");
                end else begin
                    done_t d;
                    d = exp_done.pop_front();
                    check("faint flags at done", {30'd0, faint_player, faint_enemy}, {30'd0, d.fp, d.fe});
                end
            end
        end
        prev_we = hp_we;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic setup(input logic [7:0] ps, input logic [7:0] es, input logic [7:0] php,
                         input logic [7:0] ehp, input logic [7:0] dp, input logic [7:0] de);
        player_speed = ps;
        enemy_speed  = es;
        init_php     = php;
        init_ehp     = ehp;
        dmg_p        = dp;
        dmg_e        = de;
        hp_load      = 1'b1;
        tick();
        hp_load      = 1'b0;
        tick();
    endtask

    task automatic expect_writes(input logic sel, input logic [7:0] from_hp, input int n);
        we_t e;
        for (int i = 1; i <= n; i++) begin
            e.sel   = sel;
            e.wdata = from_hp - 8'(i);
            exp_we.push_back(e);
        end
    endtask

    task automatic expect_done(input logic fp, input logic fe);
        done_t d;
        d.fp = fp;
        d.fe = fe;
        exp_done.push_back(d);
        exp_done_total++;
    endtask

    task automatic pulse_start();
        start_turn = 1'b1;
        tick();
        start_turn = 1'b0;
    endtask

    task automatic press_enter();
        keycode = ENTER;
        tick(2);
        keycode = 8'd0;
        tick();
    endtask

    task automatic wait_we_left(input int n, input int bound);
        int i = 0;
        while (exp_we.size() > n && i < bound) begin
            tick();
            i++;
        end
        if (exp_we.size() > n) begin
            checks++;
            errors++;
            $display("FAIL write timeout: %0d writes pending, wanted %0d", exp_we.size(), n);
        end
    endtask

    task automatic wait_done(input int bound);
        int i = 0;
        while (done_cnt < exp_done_total && i < bound) begin
            tick();
            i++;
        end
        check("turn_done seen", done_cnt, exp_done_total);
    endtask

    initial begin
        tick(2);
        check("outputs in reset", {20'd0, is_player, hp_we, hp_sel, hp_wdata, busy, turn_done,
                                   faint_player, faint_enemy}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: player faster, 5 damage each way
        setup(8'd50, 8'd30, 8'd40, 8'd40, 8'd5, 8'd5);
        we_cycles.delete();
        expect_writes(1'b1, 8'd40, 5);
        expect_writes(1'b0, 8'd40, 5);
        expect_done(1'b0, 1'b0);
        pulse_start();
        check("busy after start", {31'd0, busy}, 32'd1);
        wait_we_left(5, 200);
        tick(10);
        check("waits for ENTER", exp_we.size(), 5);
        check("enemy hp after move 1", {24'd0, enemy_hp}, 32'd35);
        press_enter();
        wait_we_left(0, 200);
        tick(3);
        check("no done before 2nd ENTER", done_cnt, exp_done_total - 1);
        press_enter();
        wait_done(50);
        check("player hp after move 2", {24'd0, player_hp}, 32'd35);
        check("write count", we_cycles.size(), 10);
        if (we_cycles.size() == 10) begin
            for (int i = 0; i < 4; i++) begin
                check("write spacing move 1", we_cycles[i+1] - we_cycles[i], STEP_CYCLES);
                check("write spacing move 2", we_cycles[i+6] - we_cycles[i+5], STEP_CYCLES);
            end
        end
        tick(2);
        check("busy idle", {31'd0, busy}, 32'd0);

        // 2: speed tie goes to player
        setup(8'd30, 8'd30, 8'd20, 8'd20, 8'd1, 8'd1);
        expect_writes(1'b1, 8'd20, 1);
        expect_writes(1'b0, 8'd20, 1);
        expect_done(1'b0, 1'b0);
        pulse_start();
        tick();
        check("tie: first CALC is_player", {31'd0, is_player}, 32'd1);
        wait_we_left(1, 100);
        tick(3);
        press_enter();
        wait_we_left(0, 100);
        tick(3);
        press_enter();
        wait_done(50);

        // 3: enemy faints, no enemy move
        setup(8'd50, 8'd30, 8'd40, 8'd3, 8'd10, 8'd9);
        expect_writes(1'b1, 8'd3, 3);
        expect_done(1'b0, 1'b1);
        pulse_start();
        wait_we_left(0, 100);
        tick(3);
        press_enter();
        wait_done(50);
        tick(5);
        check("faint_enemy held", {31'd0, faint_enemy}, 32'd1);
        check("player hp untouched", {24'd0, player_hp}, 32'd40);

        // 4: held ENTER does not count; start_turn mid-turn ignored
        setup(8'd50, 8'd30, 8'd30, 8'd30, 8'd2, 8'd3);
        expect_writes(1'b1, 8'd30, 2);
        expect_writes(1'b0, 8'd30, 3);
        expect_done(1'b0, 1'b0);
        pulse_start();
        check("faint cleared on start", {31'd0, faint_enemy}, 32'd0);
        keycode = ENTER;
        wait_we_left(3, 100);
        tick(10);
        check("held key no advance", exp_we.size(), 3);
        pulse_start();
        check("busy after mid-turn start", {31'd0, busy}, 32'd1);
        keycode = 8'd0;
        tick(3);
        check("release no advance", exp_we.size(), 3);
        press_enter();
        tick(8);
        pulse_start();
        wait_we_left(0, 100);
        tick(3);
        press_enter();
        wait_done(50);
        check("enemy hp test 4", {24'd0, enemy_hp}, 32'd28);

        // 5: reset in the middle of a drain
        setup(8'd50, 8'd30, 8'd40, 8'd40, 8'd5, 8'd5);
        expect_writes(1'b1, 8'd40, 2);
        pulse_start();
        wait_we_left(0, 100);
        #2;
        rst_n = 1'b0;
        #1;
        check("outputs on mid-turn reset", {20'd0, is_player, hp_we, hp_sel, hp_wdata, busy,
                                            turn_done, faint_player, faint_enemy}, 32'd0);
        tick(3);
        rst_n = 1'b1;
        tick(30);
        check("idle after reset", {31'd0, busy}, 32'd0);
        check("no writes after reset", {24'd0, enemy_hp}, 32'd38);

        // 6a: zero damage both ways
        setup(8'd50, 8'd30, 8'd20, 8'd20, 8'd0, 8'd0);
        expect_done(1'b0, 1'b0);
        pulse_start();
        tick(12);
        check("zero dmg: in ACK, player attacker", {30'd0, busy, is_player}, 32'd3);
        press_enter();
        tick(12);
        check("zero dmg: in ACK, enemy attacker", {30'd0, busy, is_player}, 32'd2);
        press_enter();
        wait_done(50);

        // 6b: fainted player skipped without ENTER; enemy hits 0-HP player
        setup(8'd50, 8'd30, 8'd0, 8'd20, 8'd7, 8'd4);
        expect_done(1'b1, 1'b0);
        pulse_start();
        tick(12);
        check("skip: enemy move awaiting ACK", {30'd0, busy, is_player}, 32'd2);
        press_enter();
        wait_done(50);
        check("enemy hp test 6b", {24'd0, enemy_hp}, 32'd20);

        tick(5);
        check("write queue drained", exp_we.size(), 0);
        check("done queue drained", exp_done.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/turn_scheduler.md
Name: turn_scheduler

Overview:
Sequences one battle turn on the shared damage-calculation datapath. It orders the two attacks by speed and drives the calculator's is_player select. It latches each damage result and drains the defender's HP register one point per animation step, then waits for an ENTER press before the next attack. It sits between the battle FSM, which issues start_turn and consumes turn_done and the faint flags, and the HP registers, which it writes through a single write port.

Parameters:
CALC_LAT, 2, cycles is_player is held stable before damage is sampled (min 1)
STEP_CYCLES, 16, clock cycles per 1-point HP decrement (min 1)
ENTER_KEY, 8'h28, keycode acknowledging a move message

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-low reset
start_turn  in  1  one-cycle pulse; starts a turn; ignored unless busy=0
player_speed  in  8  speed stat of the active player mon
enemy_speed  in  8  speed stat of the active enemy mon
player_hp  in  8  current HP of the active player mon
enemy_hp  in  8  current HP of the active enemy mon
damage  in  8  calculator result for the current is_player
keycode  in  8  keyboard keycode
is_player  out  1  calculator select; 1 = player attacks enemy
hp_we  out  1  one-cycle HP write strobe
hp_sel  out  1  write target; 0 = player HP, 1 = enemy HP
hp_wdata  out  8  HP value to write
busy  out  1  high from the cycle after an accepted start_turn until the turn_done cycle
turn_done  out  1  one-cycle pulse at end of turn
faint_player  out  1  player mon reached 0 this turn; held until next start_turn
faint_enemy  out  1  enemy mon reached 0 this turn; held until next start_turn

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0. Internal counters and latches cleared. Reset mid-turn aborts immediately and no further hp_we is issued.
- States: IDLE, ORDER, CALC, DRAIN, ACK, DONE. Registers: first_is_player, move_num (0/1), target (8b), step_cnt, calc_cnt, key_prev.
- IDLE: on start_turn, go to ORDER and clear both faint flags.
- ORDER (1 cycle): first_is_player = (player_speed >= enemy_speed); a tie goes to the player. Set move_num=0, then go to CALC.
- Attacker for the current move = first_is_player XOR move_num. is_player = attacker==player, driven from the CALC entry through ACK.
- Attacker-fainted skip: on entering CALC, if the attacker's HP is 0, skip to the next move (or DONE). No write and no ACK wait.
- CALC: hold for CALC_LAT cycles. On the last cycle latch target = defender_hp - damage, saturating at 0 (damage >= hp gives 0). Then go to DRAIN.
- DRAIN: step_cnt counts STEP_CYCLES. At each expiry, if defender_hp > target, pulse hp_we with hp_sel = defender and hp_wdata = defender_hp - 1. When defender_hp == target, go to ACK. damage=0 reaches ACK with no writes.
- Exactly one hp_we per point lost. hp_we is never asserted two consecutive cycles when STEP_CYCLES > 1.
- ACK: wait for a rising edge of (keycode==ENTER), detected against the previous-cycle compare via key_prev. A key held from earlier does not count.
- On the ACK edge:
  - if target==0, set the defender's faint flag and go to DONE (second move skipped);
  - else if move_num==0, set move_num=1 and go to CALC;
  - else go to DONE.
- DONE (1 cycle): pulse turn_done, then go to IDLE. busy=0 in IDLE and in the DONE cycle.
- start_turn while busy is ignored. A start_turn in the DONE cycle is ignored.
- Widths: all HP arithmetic is 8-bit unsigned, with no wrap below 0.

Test Plan:
1. Ordering and drain: speeds P=50/E=30, HPs P=40/E=40, damage 5 for both moves, STEP_CYCLES=4.
   -> Player attacks first: 5 hp_we with sel=1, wdata 39..35, spaced 4 cycles.
   -> Enemy attack after ENTER press: 5 writes with sel=0, wdata 39..35.
   -> turn_done after the second ENTER.
2. Speed tie: speeds 30/30.
   -> First CALC has is_player=1.
3. Faint: E_hp=3, damage=10, player faster.
   -> Writes 2,1,0 with sel=1; after ENTER faint_enemy=1, no enemy move, turn_done pulses.
4. Held key: ENTER held from before ACK is entered.
   -> No advance until release and re-press.
   -> start_turn pulsed mid-turn has no effect.
5. Reset mid-DRAIN: Reset low after 2 of 5 writes.
   -> All outputs 0 immediately, state IDLE, no further hp_we.
6. Zero damage and fainted attacker: damage=0.
   -> No hp_we, goes straight to ACK.
   -> With attacker HP=0 at CALC entry, the move is skipped without waiting for ENTER.
